// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates from a VGA-style h/v sync pair.
// Sync inputs are edge-detected on their falling edges. Those edges realign
// free-running column/line counters. A four-state tracker
// (HUNT -> H_TRACK -> V_WAIT -> LOCKED) decides when the recovered timing
// can be trusted. Every output is registered with one cycle of latency.
// sync_err is registered alongside pix_x/pix_y, so a pulse reports the
// counter position at which the violation was detected.
module vga_sync_rx #(
  parameter int HV         = 1920,
  parameter int HFP        = 88,
  parameter int HSP        = 44,
  parameter int HBP        = 148,
  parameter int VV         = 1080,
  parameter int VFP        = 4,
  parameter int VSP        = 5,
  parameter int VBP        = 36,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk_148Mhz,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [3:0]  pix_red,
  output logic [3:0]  pix_green,
  output logic [3:0]  pix_blue,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam int H_MAX      = HV + HFP + HSP + HBP - 1;
  localparam int V_MAX      = VV + VFP + VSP + VBP - 1;
  localparam int H_SYNC_END = HV + HFP + HSP;
  localparam int V_SYNC_END = VV + VFP + VSP;

  localparam logic [11:0] HC_MAX      = 12'(H_MAX);
  localparam logic [11:0] HC_SYNC_END = 12'(H_SYNC_END);
  localparam logic [11:0] HC_EDGE     = 12'(H_SYNC_END - 1);
  localparam logic [11:0] HC_VIS      = 12'(HV);
  localparam logic [10:0] VC_MAX      = 11'(V_MAX);
  localparam logic [10:0] VC_SYNC_END = 11'(V_SYNC_END);
  localparam logic [10:0] VC_EDGE     = 11'(V_SYNC_END - 1);
  localparam logic [10:0] VC_VIS      = 11'(VV);
  localparam logic [3:0]  GOOD_TARGET = 4'(LOCK_LINES);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    H_TRACK = 2'd1,
    V_WAIT  = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        hs_d_q, hs_d_d;
  logic        vs_d_q, vs_d_d;
  logic [11:0] hc_q, hc_d;
  logic [10:0] vc_q, vc_d;
  logic [3:0]  good_lines_q, good_lines_d;
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [10:0] pix_y_q, pix_y_d;
  logic [3:0]  pix_red_q, pix_red_d;
  logic [3:0]  pix_green_q, pix_green_d;
  logic [3:0]  pix_blue_q, pix_blue_d;
  logic        frame_start_q, frame_start_d;
  logic        sync_err_q, sync_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic hs_fall, vs_fall;
  logic h_at_edge, v_at_edge;
  logic h_bad, v_bad, h_good;

  // Falling-edge detect and classification against the expected edge slots.
  // A "bad" edge is either a fall in the wrong slot or a slot with no fall.
  always_comb begin
    hs_d_d    = h_sync;
    vs_d_d    = v_sync;
    hs_fall   = hs_d_q & ~h_sync;
    vs_fall   = vs_d_q & ~v_sync;
    h_at_edge = (hc_q == HC_EDGE);
    v_at_edge = (hc_q == HC_MAX) && (vc_q == VC_EDGE);
    h_bad     = hs_fall ^ h_at_edge;
    v_bad     = vs_fall ^ v_at_edge;
    h_good    = hs_fall & h_at_edge;
  end

  // Free-running column/line counters, realigned by the sync falling edges.
  always_comb begin
    hc_d = hc_q + 12'd1;
    if (hs_fall) begin
      hc_d = HC_SYNC_END;
    end else if (hc_q == HC_MAX) begin
      hc_d = '0;
    end

    vc_d = vc_q;
    if (vs_fall) begin
      vc_d = VC_SYNC_END;
    end else if (hc_q == HC_MAX) begin
      vc_d = (vc_q == VC_MAX) ? '0 : vc_q + 11'd1;
    end
  end

  // Lock tracker next-state logic; errors are only reported once LOCKED.
  always_comb begin
    state_d      = state_q;
    good_lines_d = good_lines_q;
    sync_err_d   = 1'b0;
    case (state_q)
      HUNT: begin
        if (hs_fall) begin
          state_d      = H_TRACK;
          good_lines_d = '0;
        end
      end
      H_TRACK: begin
        if (h_bad) begin
          state_d = HUNT;
        end else if (h_good) begin
          good_lines_d = good_lines_q + 4'd1;
          if (good_lines_d == GOOD_TARGET) begin
            state_d = V_WAIT;
          end
        end
      end
      V_WAIT: begin
        if (h_bad) begin
          state_d = HUNT;
        end else if (vs_fall) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // A horizontal fault outranks a vertical one: one pulse, back to HUNT.
        if (h_bad) begin
          sync_err_d = 1'b1;
          state_d    = HUNT;
        end else if (v_bad) begin
          sync_err_d = 1'b1;
          state_d    = V_WAIT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Output stage next values: coordinates, colour, gated valid and the error counter.
  always_comb begin
    pix_x_d       = hc_q[10:0];
    pix_y_d       = vc_q;
    pix_red_d     = red;
    pix_green_d   = green;
    pix_blue_d    = blue;
    pix_valid_d   = (state_q == LOCKED) && (hc_q < HC_VIS) && (vc_q < VC_VIS);
    frame_start_d = pix_valid_d && (hc_q == 12'd0) && (vc_q == 11'd0);
    err_count_d   = err_count_q;
    if (sync_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_148Mhz) begin
    if (!reset) begin
      state_q       <= HUNT;
      hs_d_q        <= 1'b0;
      vs_d_q        <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      good_lines_q  <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_red_q     <= '0;
      pix_green_q   <= '0;
      pix_blue_q    <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      hs_d_q        <= hs_d_d;
      vs_d_q        <= vs_d_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      good_lines_q  <= good_lines_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_red_q     <= pix_red_d;
      pix_green_q   <= pix_green_d;
      pix_blue_q    <= pix_blue_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_red     = pix_red_q;
  assign pix_green   = pix_green_q;
  assign pix_blue    = pix_blue_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx. It uses a scaled-down raster with the same porch and
// sync structure, so many frames fit in a short run. A timing source drives
// the DUT. A reference model, built from the timing rules, predicts every
// output cycle by cycle.
module tb_vga_sync_rx;

  localparam int T_HV = 16, T_HFP = 4, T_HSP = 3, T_HBP = 5;
  localparam int T_VV = 8, T_VFP = 2, T_VSP = 2, T_VBP = 3;
  localparam int T_LOCK = 4;
  localparam int H_TOT = T_HV + T_HFP + T_HSP + T_HBP;
  localparam int V_TOT = T_VV + T_VFP + T_VSP + T_VBP;
  localparam int H_MAX = H_TOT - 1;
  localparam int H_SE  = T_HV + T_HFP + T_HSP;
  localparam int V_SE  = T_VV + T_VFP + T_VSP;
  localparam int FRAME = H_TOT * V_TOT;
  // Lock progress as a single number: -1 hunting, 0..T_LOCK-1 good lines seen,
  // T_LOCK waiting for vertical sync, T_LOCK+1 locked.
  localparam int LVL_HUNT   = -1;
  localparam int LVL_VWAIT  = T_LOCK;
  localparam int LVL_LOCKED = T_LOCK + 1;

  logic        clk_148Mhz = 1'b0;
  logic        reset = 1'b0;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b0;
  logic [3:0]  red = '0, green = '0, blue = '0;
  logic        pix_valid, frame_start, locked, sync_err;
  logic [10:0] pix_x, pix_y;
  logic [3:0]  pix_red, pix_green, pix_blue;
  logic [7:0]  err_count;

  vga_sync_rx #(
    .HV(T_HV), .HFP(T_HFP), .HSP(T_HSP), .HBP(T_HBP),
    .VV(T_VV), .VFP(T_VFP), .VSP(T_VSP), .VBP(T_VBP),
    .LOCK_LINES(T_LOCK)
  ) dut (
    .clk_148Mhz (clk_148Mhz),
    .reset      (reset),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_red    (pix_red),
    .pix_green  (pix_green),
    .pix_blue   (pix_blue),
    .frame_start(frame_start),
    .locked     (locked),
    .sync_err   (sync_err),
    .err_count  (err_count)
  );

  // Clock and watchdog.
  always #5 clk_148Mhz = ~clk_148Mhz;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state.
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  // Reference model state.
  int m_lvl = LVL_HUNT, m_hc = 0, m_vc = 0, m_cnt = 0;
  bit m_hs_prev = 0, m_vs_prev = 0;

  // Source state.
  int sh = 0, sv = 0, prev_sh = 0, prev_sv = 0, cap_col = 0, cap_row = 0;
  bit h_del_pend = 0, h_del_act = 0, v_om_pend = 0, v_om_act = 0;
  bit force_v = 0, force_tgl = 1, glitch = 0, y_chk = 1;
  int n_serr = 0, n_early_valid = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_out(input logic v, input logic fs, input logic lk,
      input logic se, input logic [7:0] ec, input logic [10:0] x, input logic [10:0] y,
      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    return {18'd0, v, fs, lk, se, ec, x, y, r, g, b};
  endfunction

  // Reference model: predicts the outputs after the coming clock edge.
  task automatic model_step(input bit hs, input bit vs, input logic [3:0] r,
      input logic [3:0] g, input logic [3:0] b, input bit rst_n);
    bit hf, vf, h_slot, v_slot, h_bad, v_bad, e_valid, e_fs, e_err;
    int n_hc, n_vc;
    if (!rst_n) begin
      m_lvl = LVL_HUNT; m_hc = 0; m_vc = 0; m_cnt = 0;
      m_hs_prev = 0; m_vs_prev = 0;
      exp_q.push_back(64'd0);
      return;
    end
    hf     = m_hs_prev && !hs;
    vf     = m_vs_prev && !vs;
    h_slot = (m_hc == H_SE - 1);
    v_slot = (m_hc == H_MAX) && (m_vc == V_SE - 1);
    h_bad  = (hf != h_slot);
    v_bad  = (vf != v_slot);
    e_valid = (m_lvl == LVL_LOCKED) && (m_hc < T_HV) && (m_vc < T_VV);
    e_fs    = e_valid && (m_hc == 0) && (m_vc == 0);
    e_err   = 0;
    if (m_lvl == LVL_HUNT) begin
      if (hf) m_lvl = 0;
    end else if (m_lvl < LVL_VWAIT) begin
      if (h_bad) m_lvl = LVL_HUNT;
      else if (hf) m_lvl = m_lvl + 1;
    end else if (m_lvl == LVL_VWAIT) begin
      if (h_bad) m_lvl = LVL_HUNT;
      else if (vf) m_lvl = LVL_LOCKED;
    end else begin
      if (h_bad) begin e_err = 1; m_lvl = LVL_HUNT; end
      else if (v_bad) begin e_err = 1; m_lvl = LVL_VWAIT; end
    end
    if (e_err && m_cnt < 255) m_cnt++;
    exp_q.push_back(pack_out(e_valid, e_fs, m_lvl == LVL_LOCKED, e_err, 8'(m_cnt),
                             11'(m_hc % 2048), 11'(m_vc), r, g, b));
    n_hc = hf ? H_SE : (m_hc + 1) % H_TOT;
    n_vc = vf ? V_SE : ((m_hc == H_MAX) ? (m_vc + 1) % V_TOT : m_vc);
    m_hc = n_hc;
    m_vc = n_vc;
    m_hs_prev = hs;
    m_vs_prev = vs;
  endtask

  // Driver: apply one cycle of inputs, clock, then compare away from the edge.
  task automatic tick(input bit hs, input bit vs, input logic [3:0] r, input logic [3:0] g,
      input logic [3:0] b, input bit rst_n);
    h_sync = hs; v_sync = vs; red = r; green = g; blue = b; reset = rst_n;
    model_step(hs, vs, r, g, b, rst_n);
    @(posedge clk_148Mhz);
    #1;
    check_val("outputs", pack_out(pix_valid, frame_start, locked, sync_err, err_count,
              pix_x, pix_y, pix_red, pix_green, pix_blue), exp_q.pop_front());
    if (pix_valid) begin
      check_val("x_align", 64'(pix_x), 64'(cap_col));
      check_val("red_pattern", 64'(pix_red), 64'(cap_col % 16));
      if (y_chk) check_val("y_align", 64'(pix_y), 64'(cap_row));
    end
    if (sync_err) n_serr++;
    if (pix_valid && !locked) n_early_valid++;
  endtask

  // Timing source: one raster position per cycle, colour one cycle late.
  task automatic src_cycle(input bit rst_n);
    int hpos;
    bit hs, vs;
    if (sh == 0) begin
      h_del_act = h_del_pend; h_del_pend = 0;
      if (sv == 0) begin v_om_act = v_om_pend; v_om_pend = 0; end
    end
    hpos = h_del_act ? sh - 1 : sh;
    hs = (hpos >= T_HV + T_HFP) && (hpos < H_SE);
    vs = !v_om_act && (sv >= T_VV + T_VFP) && (sv < V_SE);
    if (force_v) begin vs = force_tgl; force_tgl = !force_tgl; end
    if (glitch) begin
      if ($urandom_range(0, 63) == 0) hs = !hs;
      if ($urandom_range(0, 63) == 0) vs = !vs;
    end
    cap_col = prev_sh;
    cap_row = prev_sv;
    tick(hs, vs, 4'(prev_sh), 4'(prev_sv), 4'($urandom_range(0, 15)), rst_n);
    prev_sh = sh;
    prev_sv = sv;
    sh = (sh + 1) % H_TOT;
    if (sh == 0) sv = (sv + 1) % V_TOT;
  endtask

  task automatic wait_locked(input int budget, input string tag, output int cycles);
    cycles = 0;
    while (!locked && cycles < budget) begin
      src_cycle(1);
      cycles++;
    end
    check_val(tag, 64'(locked), 64'd1);
  endtask

  task automatic wait_frame_start(input int budget, input string tag);
    int i;
    i = 0;
    while (!frame_start && i < budget) begin
      src_cycle(1);
      i++;
    end
    check_val(tag, 64'(frame_start), 64'd1);
  endtask

  initial begin
    int cyc, base, tot, runs, cur, mn, mx, ev_base;
    bit pv;

    // Reset while the source free-runs from a random raster position.
    sh = $urandom_range(0, H_TOT - 1);
    sv = $urandom_range(0, V_TOT - 1);
    repeat ($urandom_range(3, FRAME)) src_cycle(0);
    check_val("reset_outputs", pack_out(pix_valid, frame_start, locked, sync_err, err_count,
              pix_x, pix_y, pix_red, pix_green, pix_blue), 64'd0);

    // Clean source: lock, then measure one complete frame.
    wait_locked(3 * FRAME, "clean_lock", cyc);
    wait_frame_start(FRAME + 10, "clean_frame_start");
    check_val("fs_pix_x", 64'(pix_x), 64'd0);
    check_val("fs_pix_y", 64'(pix_y), 64'd0);
    tot = 1; runs = 1; cur = 1; mn = 1 << 30; mx = 0; pv = 1;
    for (int i = 1; i < FRAME; i++) begin
      src_cycle(1);
      if (pix_valid) begin
        tot++;
        if (pv) cur++;
        else begin runs++; cur = 1; end
      end else if (pv) begin
        if (cur < mn) mn = cur;
        if (cur > mx) mx = cur;
      end
      pv = pix_valid;
    end
    if (pv) begin
      if (cur < mn) mn = cur;
      if (cur > mx) mx = cur;
    end
    check_val("valid_total", 64'(tot), 64'(T_HV * T_VV));
    check_val("valid_lines", 64'(runs), 64'(T_VV));
    check_val("valid_run_min", 64'(mn), 64'(T_HV));
    check_val("valid_run_max", 64'(mx), 64'(T_HV));
    check_val("clean_err_count", 64'(err_count), 64'd0);

    // One horizontal sync pulse delayed by a cycle while locked.
    base = n_serr;
    h_del_pend = 1;
    repeat (2 * H_TOT) src_cycle(1);
    check_val("hdel_lock_dropped", 64'(locked), 64'd0);
    wait_locked(3 * FRAME, "hdel_relock", cyc);
    check_val("hdel_single_err", 64'(n_serr - base), 64'd1);
    check_val("hdel_err_count", 64'(err_count), 64'd1);

    // One vertical sync pulse omitted while locked.
    base = n_serr;
    v_om_pend = 1;
    cyc = 0;
    while (!sync_err && cyc < 2 * FRAME) begin
      src_cycle(1);
      cyc++;
    end
    check_val("vom_err_seen", 64'(sync_err), 64'd1);
    check_val("vom_err_x", 64'(pix_x), 64'(H_MAX));
    check_val("vom_err_y", 64'(pix_y), 64'(V_SE - 1));
    check_val("vom_lock_dropped", 64'(locked), 64'd0);
    wait_locked(FRAME + H_TOT, "vom_relock", cyc);
    check_val("vom_relock_cycles", 64'(cyc), 64'(FRAME));
    check_val("vom_single_err", 64'(n_serr - base), 64'd1);
    check_val("vom_err_count", 64'(err_count), 64'd2);

    // Reset held for three cycles in the middle of an active line.
    cyc = 0;
    while (!(pix_valid && pix_x >= 11'd4) && cyc < 2 * FRAME) begin
      src_cycle(1);
      cyc++;
    end
    check_val("rst_mid_line", 64'(pix_valid), 64'd1);
    src_cycle(0);
    check_val("rst_outputs_zero", pack_out(pix_valid, frame_start, locked, sync_err, err_count,
              pix_x, pix_y, pix_red, pix_green, pix_blue), 64'd0);
    src_cycle(0);
    src_cycle(0);
    ev_base = n_early_valid;
    wait_locked(3 * FRAME, "rst_relock", cyc);
    check_val("rst_no_early_valid", 64'(n_early_valid - ev_base), 64'd0);
    check_val("rst_full_relock", 64'(cyc >= T_LOCK * H_TOT), 64'd1);
    check_val("rst_err_count", 64'(err_count), 64'd0);

    // Random sync glitches; the model follows every transition.
    y_chk = 0;
    glitch = 1;
    repeat (2 * FRAME) src_cycle(1);
    glitch = 0;
    wait_locked(3 * FRAME, "glitch_relock", cyc);

    // Rapid vertical-sync toggling forces an error every four cycles.
    force_v = 1;
    force_tgl = 1;
    repeat (1400) src_cycle(1);
    check_val("sat_err_count", 64'(err_count), 64'd255);
    repeat (40) src_cycle(1);
    check_val("sat_err_hold", 64'(err_count), 64'd255);
    force_v = 0;
    repeat (H_TOT) src_cycle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: HV 1920 visible px/line; HFP 88; HSP 44; HBP 148; VV 1080 visible lines; VFP 4; VSP 5; VBP 36; LOCK_LINES 4 consecutive good lines needed for horizontal lock.
REQ-002 Derived: H_MAX = HV+HFP+HSP+HBP-1 (2199); V_MAX = VV+VFP+VSP+VBP-1 (1124); H_SYNC_END = HV+HFP+HSP (2052); V_SYNC_END = VV+VFP+VSP (1089).
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk_148Mhz in 1: pixel clock, sole clock.
- reset in 1: synchronous, active-low reset.
- h_sync in 1: active-high horizontal sync, synchronous to clk_148Mhz.
- v_sync in 1: active-high vertical sync, synchronous.
- red, green, blue in 4 each: pixel colour, one cycle behind sync.
- pix_valid out 1: output pixel inside visible area and receiver LOCKED.
- pix_x out 11: recovered column.
- pix_y out 11: recovered line.
- pix_red, pix_green, pix_blue out 4 each: captured colour.
- frame_start out 1: one-cycle pulse coincident with pixel (0,0).
- locked out 1: state == LOCKED.
- sync_err out 1: one-cycle pulse on timing violation while LOCKED.
- err_count out 8: saturating count of sync_err pulses.

Function
REQ-004 Edge detect: hs_d/vs_d SHALL register the inputs; hs_fall = hs_d & ~h_sync; vs_fall = vs_d & ~v_sync.
REQ-005 Column counter hc (12 bit): hs_fall -> hc <= H_SYNC_END; else hc == H_MAX -> 0; else hc+1.
REQ-006 Line counter vc (11 bit): vs_fall -> vc <= V_SYNC_END (priority); else hc == H_MAX -> vc+1, wrapping V_MAX -> 0; else hold.
REQ-007 With this alignment, the colour input on a cycle where hc = k, vc = j SHALL be treated as pixel (k, j).
REQ-008 Expected h edge: hs_fall while hc == H_SYNC_END-1. h mismatch: hs_fall with any other hc. h miss: hc == H_SYNC_END-1 with no hs_fall.
REQ-009 Expected v edge: vs_fall while hc == H_MAX and vc == V_SYNC_END-1. v mismatch: vs_fall otherwise. v miss: hc == H_MAX, vc == V_SYNC_END-1, no vs_fall.
REQ-010 FSM states SHALL be HUNT, H_TRACK, V_WAIT, LOCKED; good_lines is a 4-bit counter.
REQ-011 HUNT: on hs_fall -> H_TRACK, good_lines <= 0.
REQ-012 H_TRACK: each expected h edge increments good_lines; reaching LOCK_LINES -> V_WAIT; h mismatch or miss -> HUNT. No sync_err is raised.
REQ-013 V_WAIT: any vs_fall -> LOCKED. h mismatch or miss -> HUNT. No sync_err is raised.
REQ-014 LOCKED: h mismatch or miss -> sync_err, HUNT. v mismatch or miss -> sync_err, V_WAIT. If both occur on one cycle, exactly one pulse is raised and the next state is HUNT.
REQ-015 Output stage SHALL be registered with latency one cycle:
- pix_x <= hc[10:0]; pix_y <= vc.
- pix_red/green/blue <= red/green/blue.
- pix_valid <= (state == LOCKED) & hc < HV & vc < VV.
REQ-016 frame_start SHALL be registered with pix_valid and SHALL be high only when pix_valid, pix_x == 0 and pix_y == 0.
REQ-017 err_count SHALL increment on each sync_err and saturate at 255.
REQ-018 Counters SHALL free-run in every state; only pix_valid and frame_start are gated by lock.

Reset
REQ-019 When reset == 0 at a clock edge, the following SHALL clear: state -> HUNT; hc, vc, good_lines, hs_d, vs_d -> 0; all outputs -> 0, including err_count.
REQ-020 Reset mid-frame SHALL abandon lock immediately; relock requires a full HUNT -> LOCKED sequence.

Verification
REQ-021 Bench SHALL drive a 1920x1080 timing source (h_sync at h 2008..2051, v_sync at v 1084..1088, colour registered one cycle late) and cover:
- Clean source from reset: locked rises after 4 good lines plus the first vs_fall; the next frame gives frame_start with pix_x=0, pix_y=0; pix_valid spans exactly 1920 cycles per line on 1080 lines; err_count=0.
- Colour pattern pixel(k,j) = k[3:0]: pix_red == pix_x[3:0] on every pix_valid cycle.
- One hsync pulse delayed 1 cycle while LOCKED: single sync_err, locked drops, err_count=1, relock after 4 lines plus vsync.
- One vsync pulse omitted while LOCKED: sync_err at hc=2199, vc=1088; state V_WAIT; locked returns on the next vs_fall.
- Reset asserted mid-active-line for 3 cycles: all outputs 0 on the following cycle; no pix_valid until a full relock.
- 300 forced errors: err_count holds at 255.
